// File: rtl/helper_arbiter_if.sv
// Request/response bundle between N client blocks and the shared helper arbiter.
// master = client/downstream side, slave = arbiter side.
interface helper_arbiter_if #(
    parameter int N = 4,
    parameter int W = 4
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic [W-1:0]   rsp_data;
    logic [IDW-1:0] rsp_id;
    logic           rsp_ready;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/helper_arbiter.sv
// Round-robin arbiter sharing one bitwise-invert helper among N requesters.
// The result is registered and tagged with the owner's index.
module helper #(
    parameter int W = 4
) (
    input  logic [W-1:0] a_i,
    output logic [W-1:0] y_o
);
    assign y_o = ~a_i;
endmodule

module helper_arbiter #(
    parameter int N = 4,
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    helper_arbiter_if.slave  bus
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] rsp_id_q;
    logic [W-1:0]   rsp_data_q;
    logic [IDW-1:0] grant, scan_idx;
    logic [W-1:0]   sel_data, inv_data;
    logic           found, any_req, load, accept;

    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    always_comb begin : arbitrate
        grant    = rr_ptr_q;
        found    = 1'b0;
        scan_idx = rr_ptr_q;
        for (int k = 0; k < N; k++) begin
            if (!found && bus.req_valid[scan_idx]) begin
                grant = scan_idx;
                found = 1'b1;
            end
            scan_idx = (scan_idx == IDW'(N - 1)) ? '0 : scan_idx + 1'b1;
        end
    end

    always_comb begin : operand_mux
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant == IDW'(i)) sel_data = bus.req_data[i*W +: W];
        end
    end

    helper #(.W(W)) u_helper (
        .a_i (sel_data),
        .y_o (inv_data)
    );

    assign any_req = |bus.req_valid;
    assign load    = (state_q == IDLE) || (state_q == HOLD && bus.rsp_ready);
    // Gated by rst_n so nothing is offered as accepted while reset is held.
    assign accept  = rst_n && load && any_req;

    always_comb begin : ready_decode
        bus.req_ready = '0;
        for (int i = 0; i < N; i++) begin
            bus.req_ready[i] = accept && (grant == IDW'(i));
        end
    end

    always_comb begin : next_state
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (grant == IDW'(N - 1)) ? '0 : grant + 1'b1;
        end
        case (state_q)
            IDLE:    if (any_req) state_d = HOLD;
            HOLD:    if (bus.rsp_ready && !any_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    // NOTE: the response register is reset too, so a held response never survives reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            if (accept) begin
                rsp_data_q <= inv_data;
                rsp_id_q   <= grant;
            end
        end
    end

    assign bus.rsp_valid = (state_q == HOLD);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
endmodule

// File: tb/tb_helper_arbiter.sv
// Directed self-checking bench for helper_arbiter with N=4, W=4.
module tb_helper_arbiter;
    localparam logic [15:0] DATA = 16'h73A5;  // req3=7, req2=3, req1=A, req0=5

    logic clk;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    logic [3:0] exp_inv [4] = '{4'hA, 4'h5, 4'hC, 4'h8};

    helper_arbiter_if #(.N(4), .W(4)) bus ();

    helper_arbiter #(.N(4), .W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid = 4'b0000;
        bus.rsp_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_data  = DATA;
        bus.rsp_ready = 1'b1;
        repeat (3) tick();
        tests++;
        if ({bus.rsp_valid, bus.rsp_data, bus.rsp_id} !== 7'b0) begin
            fails++;
            $display("FAIL reset_rsp: got %b, expected %b", {bus.rsp_valid, bus.rsp_data, bus.rsp_id}, 7'b0);
        end
        tests++;
        if (bus.req_ready !== 4'b0000) begin
            fails++;
            $display("FAIL reset_ready: got %b, expected %b", bus.req_ready, 4'b0000);
        end
        rst_n = 1'b1;
        #1;
        tests++;
        if (bus.req_ready !== 4'b0001) begin
            fails++;
            $display("FAIL first_grant: got %b, expected %b", bus.req_ready, 4'b0001);
        end
        tick();
        tests++;
        if ({bus.rsp_valid, bus.rsp_data, bus.rsp_id} !== {1'b1, 4'hA, 2'd0}) begin
            fails++;
            $display("FAIL first_rsp: got %b, expected %b", {bus.rsp_valid, bus.rsp_data, bus.rsp_id}, {1'b1, 4'hA, 2'd0});
        end
        bus.req_valid = 4'b0000;
        tick();
        tests++;
        if (bus.rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL drain_idle: got %b, expected %b", bus.rsp_valid, 1'b0);
        end
    endtask

    task automatic test_single();
        bus.req_valid = 4'b0100;
        #1;
        tests++;
        if (bus.req_ready !== 4'b0100) begin
            fails++;
            $display("FAIL single_ready: got %b, expected %b", bus.req_ready, 4'b0100);
        end
        tick();
        tests++;
        if ({bus.rsp_valid, bus.rsp_data, bus.rsp_id} !== {1'b1, 4'hC, 2'd2}) begin
            fails++;
            $display("FAIL single_rsp: got %b, expected %b", {bus.rsp_valid, bus.rsp_data, bus.rsp_id}, {1'b1, 4'hC, 2'd2});
        end
        // rr_ptr should now be 3: requesters 0,1,3 valid must pick 3.
        bus.req_valid = 4'b1011;
        #1;
        tests++;
        if (bus.req_ready !== 4'b1000) begin
            fails++;
            $display("FAIL single_rrptr: got %b, expected %b", bus.req_ready, 4'b1000);
        end
        bus.req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_wrap();
        bus.req_valid = 4'b0010;
        #1;
        tests++;
        if (bus.req_ready !== 4'b0010) begin
            fails++;
            $display("FAIL wrap_ready: got %b, expected %b", bus.req_ready, 4'b0010);
        end
        tick();
        tests++;
        if ({bus.rsp_valid, bus.rsp_data, bus.rsp_id} !== {1'b1, 4'h5, 2'd1}) begin
            fails++;
            $display("FAIL wrap_rsp: got %b, expected %b", {bus.rsp_valid, bus.rsp_data, bus.rsp_id}, {1'b1, 4'h5, 2'd1});
        end
        // rr_ptr should now be 2: requesters 0,2 valid must pick 2.
        bus.req_valid = 4'b0101;
        #1;
        tests++;
        if (bus.req_ready !== 4'b0100) begin
            fails++;
            $display("FAIL wrap_rrptr: got %b, expected %b", bus.req_ready, 4'b0100);
        end
        bus.req_valid = 4'b0000;
        tick();
        tests++;
        if (bus.rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL wrap_idle: got %b, expected %b", bus.rsp_valid, 1'b0);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            tests++;
            if ({bus.rsp_valid, bus.rsp_data, bus.rsp_id} !== {1'b1, exp_inv[i % 4], 2'(i % 4)}) begin
                fails++;
                $display("FAIL rr_seq[%0d]: got %b, expected %b", i,
                         {bus.rsp_valid, bus.rsp_data, bus.rsp_id}, {1'b1, exp_inv[i % 4], 2'(i % 4)});
            end
        end
    endtask

    task automatic test_backpressure();
        // Holding requester 3's response with all four still requesting.
        bus.rsp_ready = 1'b0;
        #1;
        tests++;
        if (bus.req_ready !== 4'b0000) begin
            fails++;
            $display("FAIL bp_ready_now: got %b, expected %b", bus.req_ready, 4'b0000);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if ({bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.req_ready} !== {1'b1, 4'h8, 2'd3, 4'b0000}) begin
                fails++;
                $display("FAIL bp_hold[%0d]: got %b, expected %b", i,
                         {bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.req_ready}, {1'b1, 4'h8, 2'd3, 4'b0000});
            end
        end
        bus.rsp_ready = 1'b1;
        #1;
        tests++;
        if (bus.req_ready !== 4'b0001) begin
            fails++;
            $display("FAIL bp_release_ready: got %b, expected %b", bus.req_ready, 4'b0001);
        end
        tick();
        tests++;
        if ({bus.rsp_valid, bus.rsp_data, bus.rsp_id} !== {1'b1, 4'hA, 2'd0}) begin
            fails++;
            $display("FAIL bp_release_rsp: got %b, expected %b", {bus.rsp_valid, bus.rsp_data, bus.rsp_id}, {1'b1, 4'hA, 2'd0});
        end
        bus.req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_async_reset();
        bus.req_valid = 4'b0100;
        bus.rsp_ready = 1'b1;
        tick();
        tests++;
        if ({bus.rsp_valid, bus.rsp_data, bus.rsp_id} !== {1'b1, 4'hC, 2'd2}) begin
            fails++;
            $display("FAIL areset_setup: got %b, expected %b", {bus.rsp_valid, bus.rsp_data, bus.rsp_id}, {1'b1, 4'hC, 2'd2});
        end
        bus.req_valid = 4'b0000;
        bus.rsp_ready = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.rsp_valid, bus.rsp_data, bus.rsp_id} !== 7'b0) begin
            fails++;
            $display("FAIL areset_drop: got %b, expected %b", {bus.rsp_valid, bus.rsp_data, bus.rsp_id}, 7'b0);
        end
        #2;
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (bus.rsp_valid !== 1'b0) begin
                fails++;
                $display("FAIL areset_noreplay[%0d]: got %b, expected %b", i, bus.rsp_valid, 1'b0);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.req_valid = 4'b0000;
        bus.req_data  = DATA;
        bus.rsp_ready = 1'b1;
        test_reset();
        test_single();
        test_wrap();
        test_round_robin();
        test_backpressure();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
